// File: rtl/intf_slot_arb_pkg.sv
// Shared types and helpers for the interface-slot arbiter.
package intf_slot_arb_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  // Width of an index field that addresses n items; never narrower than 1 bit.
  function automatic int idx_w(input int n);
    if (n <= 2) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/intf_slot_arbiter_if.sv
// Requester-side bundle for intf_slot_arbiter: request/write inputs and
// grant/slot outputs. The master modport is the requester logic, the slave
// modport is the arbiter itself.
interface intf_slot_arbiter_if #(
  parameter int N_REQ   = 4,
  parameter int N_SLOTS = 4
);
  import intf_slot_arb_pkg::*;

  localparam int RW = idx_w(N_REQ);
  localparam int SW = idx_w(N_SLOTS);

  logic [N_REQ-1:0]    req;
  logic [N_REQ-1:0]    wr_en;
  logic [N_REQ*SW-1:0] wr_slot;
  logic [N_REQ-1:0]    wr_bit;
  logic [N_REQ-1:0]    gnt;
  logic [RW-1:0]       gnt_idx;
  logic                busy;
  logic [N_SLOTS-1:0]  slot_a;
  logic                bad_slot;
  logic                timeout;

  modport master (
    output req, wr_en, wr_slot, wr_bit,
    input  gnt, gnt_idx, busy, slot_a, bad_slot, timeout
  );

  modport slave (
    input  req, wr_en, wr_slot, wr_bit,
    output gnt, gnt_idx, busy, slot_a, bad_slot, timeout
  );

endinterface

// File: rtl/intf_slot_arbiter_rr_pick.sv
// Combinational round-robin picker: scans req starting at ptr and wrapping,
// returning the first set requester as one-hot plus binary index.
module rr_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  output logic [N-1:0] onehot_o,
  output logic [W-1:0] idx_o,
  output logic         any_o
);

  // Position of the off-th candidate after base, wrapped into 0..n-1.
  function automatic int wrap_idx(input int base, input int off, input int n);
    int sum;
    sum = base + off;
    return (sum >= n) ? (sum - n) : sum;
  endfunction

  // First requester at or after ptr wins; later candidates are masked once found.
  always_comb begin
    any_o    = 1'b0;
    idx_o    = '0;
    onehot_o = '0;
    for (int i = 0; i < N; i++) begin
      if (!any_o && req_i[wrap_idx(int'(ptr_i), i, N)]) begin
        any_o = 1'b1;
        idx_o = W'(wrap_idx(int'(ptr_i), i, N));
      end else begin
        any_o = any_o;
      end
    end
    if (any_o) begin
      onehot_o[idx_o] = 1'b1;
    end else begin
      onehot_o = '0;
    end
  end

endmodule

// File: rtl/intf_slot_arbiter.sv
// intf_slot_arbiter: round-robin ownership of an array of single-bit
// interface slots. The current owner may write any slot by index.
// Optional hold limit: define INTF_SLOT_ARB_TIMEOUT_EN to revoke a grant
// after MAX_HOLD consecutive cycles (timeout pulses on revocation).
module intf_slot_arbiter
  import intf_slot_arb_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int N_SLOTS  = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic               clk,
  input  logic               rst,
  intf_slot_arbiter_if.slave bus
);

  localparam int RW = idx_w(N_REQ);
  localparam int SW = idx_w(N_SLOTS);

  arb_state_e         state_q, state_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic [RW-1:0]      owner_q, owner_d;
  logic [RW-1:0]      ptr_q, ptr_d;
  logic               busy_q, busy_d;
  logic [N_SLOTS-1:0] slot_a_q, slot_a_d;
  logic               bad_slot_q, bad_slot_d;
  logic               timeout_q, timeout_d;

  logic [N_REQ-1:0]   pick_onehot_s;
  logic [RW-1:0]      pick_idx_s;
  logic               pick_any_s;
  logic [RW-1:0]      next_ptr_s;
  logic [SW-1:0]      wr_idx_s;

`ifdef INTF_SLOT_ARB_TIMEOUT_EN
  localparam int HW = idx_w(MAX_HOLD);
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic          limit_s;
  assign limit_s = (hold_cnt_q == HW'(MAX_HOLD - 1));
`endif

  rr_pick #(.N(N_REQ), .W(RW)) u_pick (
    .req_i    (bus.req),
    .ptr_i    (ptr_q),
    .onehot_o (pick_onehot_s),
    .idx_o    (pick_idx_s),
    .any_o    (pick_any_s)
  );

  // After a release the departing owner drops to lowest priority.
  assign next_ptr_s = (owner_q == RW'(N_REQ - 1)) ? '0 : owner_q + RW'(1);
  assign wr_idx_s   = bus.wr_slot[owner_q*SW +: SW];

  // Arbitration FSM: grant from IDLE, release on request drop or hold limit.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    busy_d    = busy_q;
    timeout_d = 1'b0;
`ifdef INTF_SLOT_ARB_TIMEOUT_EN
    hold_cnt_d = hold_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (pick_any_s) begin
          state_d = GRANT;
          gnt_d   = pick_onehot_s;
          owner_d = pick_idx_s;
          busy_d  = 1'b1;
`ifdef INTF_SLOT_ARB_TIMEOUT_EN
          hold_cnt_d = '0;
`endif
        end else begin
          gnt_d  = '0;
          busy_d = 1'b0;
        end
      end
      GRANT: begin
        if (!bus.req[owner_q]) begin
          state_d = IDLE;
          gnt_d   = '0;
          busy_d  = 1'b0;
          ptr_d   = next_ptr_s;
        end else begin
`ifdef INTF_SLOT_ARB_TIMEOUT_EN
          if (limit_s) begin
            state_d   = IDLE;
            gnt_d     = '0;
            busy_d    = 1'b0;
            ptr_d     = next_ptr_s;
            timeout_d = 1'b1;
          end else begin
            hold_cnt_d = hold_cnt_q + HW'(1);
          end
`else
          state_d = GRANT;
`endif
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Slot write path: only the owner's strobe counts; out-of-range index is dropped and flagged.
  always_comb begin
    slot_a_d   = slot_a_q;
    bad_slot_d = 1'b0;
    if ((state_q == GRANT) && bus.wr_en[owner_q]) begin
      if (int'(wr_idx_s) < N_SLOTS) begin
        slot_a_d[wr_idx_s] = bus.wr_bit[owner_q];
      end else begin
        bad_slot_d = 1'b1;
      end
    end else begin
      bad_slot_d = 1'b0;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      owner_q    <= '0;
      ptr_q      <= '0;
      busy_q     <= 1'b0;
      slot_a_q   <= '0;
      bad_slot_q <= 1'b0;
      timeout_q  <= 1'b0;
`ifdef INTF_SLOT_ARB_TIMEOUT_EN
      hold_cnt_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      owner_q    <= owner_d;
      ptr_q      <= ptr_d;
      busy_q     <= busy_d;
      slot_a_q   <= slot_a_d;
      bad_slot_q <= bad_slot_d;
      timeout_q  <= timeout_d;
`ifdef INTF_SLOT_ARB_TIMEOUT_EN
      hold_cnt_q <= hold_cnt_d;
`endif
    end
  end

  assign bus.gnt      = gnt_q;
  assign bus.gnt_idx  = owner_q;
  assign bus.busy     = busy_q;
  assign bus.slot_a   = slot_a_q;
  assign bus.bad_slot = bad_slot_q;
  assign bus.timeout  = timeout_q;

endmodule

// File: tb/tb_intf_slot_arbiter.sv
// Directed testbench for intf_slot_arbiter: a 4-slot instance for the main
// scenarios and a 3-slot instance for the out-of-range index case.
`timescale 1ns/1ps
module tb_intf_slot_arbiter;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  intf_slot_arbiter_if #(.N_REQ(4), .N_SLOTS(4)) bus4 ();
  intf_slot_arbiter_if #(.N_REQ(4), .N_SLOTS(3)) bus3 ();

  intf_slot_arbiter #(.N_REQ(4), .N_SLOTS(4), .MAX_HOLD(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  intf_slot_arbiter #(.N_REQ(4), .N_SLOTS(3), .MAX_HOLD(8)) dut3 (
    .clk (clk),
    .rst (rst),
    .bus (bus3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus4.req = 4'b1111;
    for (int c = 0; c < 2; c++) begin
      tick();
      n_checks++;
      if (bus4.gnt !== 4'b0000 || bus4.busy !== 1'b0 || bus4.gnt_idx !== 2'd0) begin
        n_fail++;
        $display("FAIL reset_grant: gnt=%b busy=%b idx=%0d, want 0000/0/0", bus4.gnt, bus4.busy, bus4.gnt_idx);
      end
      n_checks++;
      if (bus4.slot_a !== 4'b0000 || bus4.bad_slot !== 1'b0 || bus4.timeout !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_slots: slot_a=%b bad=%b to=%b, want 0000/0/0", bus4.slot_a, bus4.bad_slot, bus4.timeout);
      end
    end
    rst = 1'b0;
    tick();
    n_checks++;
    if (bus4.gnt !== 4'b0001 || bus4.busy !== 1'b1 || bus4.gnt_idx !== 2'd0) begin
      n_fail++;
      $display("FAIL first_grant: gnt=%b busy=%b idx=%0d, want 0001/1/0", bus4.gnt, bus4.busy, bus4.gnt_idx);
    end
  endtask

  task automatic test_fairness();
    logic [3:0] exp_gnt;
    for (int k = 0; k < 4; k++) begin
      exp_gnt = 4'b0001 << k;
      for (int c = 0; c < 3; c++) begin
        n_checks++;
        if (bus4.gnt !== exp_gnt || bus4.gnt_idx !== 2'(k)) begin
          n_fail++;
          $display("FAIL fair_owner%0d: gnt=%b idx=%0d, want %b/%0d", k, bus4.gnt, bus4.gnt_idx, exp_gnt, k);
        end
        if (c < 2) tick();
      end
      bus4.req[k] = 1'b0;
      tick();
      n_checks++;
      if (bus4.gnt !== 4'b0000 || bus4.busy !== 1'b0) begin
        n_fail++;
        $display("FAIL fair_bubble%0d: gnt=%b busy=%b, want 0000/0", k, bus4.gnt, bus4.busy);
      end
      bus4.req[k] = 1'b1;
      tick();
    end
    n_checks++;
    if (bus4.gnt !== 4'b0001) begin
      n_fail++;
      $display("FAIL fair_wrap: gnt=%b, want 0001", bus4.gnt);
    end
    bus4.req = 4'b0000;
    tick();
  endtask

  task automatic test_write();
    bus4.req = 4'b0100;
    tick();
    n_checks++;
    if (bus4.gnt !== 4'b0100) begin
      n_fail++;
      $display("FAIL write_grant: gnt=%b, want 0100", bus4.gnt);
    end
    // owner 2 -> slot 3 = 1, non-owner 1 -> slot 0 = 1 (ignored)
    bus4.wr_en   = 4'b0110;
    bus4.wr_slot = 8'h30;
    bus4.wr_bit  = 4'b0110;
    tick();
    n_checks++;
    if (bus4.slot_a !== 4'b1000 || bus4.bad_slot !== 1'b0) begin
      n_fail++;
      $display("FAIL write_owner: slot_a=%b bad=%b, want 1000/0", bus4.slot_a, bus4.bad_slot);
    end
    // write slot 1 while dropping the request: write still commits
    bus4.wr_en   = 4'b0100;
    bus4.wr_slot = 8'h10;
    bus4.wr_bit  = 4'b0100;
    bus4.req     = 4'b0000;
    tick();
    n_checks++;
    if (bus4.slot_a !== 4'b1010 || bus4.gnt !== 4'b0000) begin
      n_fail++;
      $display("FAIL write_on_drop: slot_a=%b gnt=%b, want 1010/0000", bus4.slot_a, bus4.gnt);
    end
    // strobe while nobody owns the array
    bus4.wr_slot = 8'h00;
    tick();
    n_checks++;
    if (bus4.slot_a !== 4'b1010) begin
      n_fail++;
      $display("FAIL write_idle: slot_a=%b, want 1010", bus4.slot_a);
    end
    bus4.wr_en  = 4'b0000;
    bus4.wr_bit = 4'b0000;
    tick();
  endtask

  task automatic test_bad_index();
    bus3.req = 4'b0001;
    tick();
    n_checks++;
    if (bus3.gnt !== 4'b0001) begin
      n_fail++;
      $display("FAIL bad_grant: gnt=%b, want 0001", bus3.gnt);
    end
    bus3.wr_en   = 4'b0001;
    bus3.wr_bit  = 4'b0001;
    bus3.wr_slot = 8'h02;
    tick();
    n_checks++;
    if (bus3.slot_a !== 3'b100 || bus3.bad_slot !== 1'b0) begin
      n_fail++;
      $display("FAIL bad_top_slot: slot_a=%b bad=%b, want 100/0", bus3.slot_a, bus3.bad_slot);
    end
    bus3.wr_slot = 8'h03;
    tick();
    n_checks++;
    if (bus3.slot_a !== 3'b100 || bus3.bad_slot !== 1'b1) begin
      n_fail++;
      $display("FAIL bad_pulse: slot_a=%b bad=%b, want 100/1", bus3.slot_a, bus3.bad_slot);
    end
    bus3.wr_en = 4'b0000;
    tick();
    n_checks++;
    if (bus3.bad_slot !== 1'b0 || bus3.slot_a !== 3'b100) begin
      n_fail++;
      $display("FAIL bad_clear: slot_a=%b bad=%b, want 100/0", bus3.slot_a, bus3.bad_slot);
    end
    bus3.req = 4'b0000;
    tick();
  endtask

  task automatic test_timeout();
    bus4.req = 4'b0011;
    for (int n = 1; n <= 8; n++) begin
      tick();
      n_checks++;
      if (bus4.gnt !== 4'b0001 || bus4.timeout !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_cycle%0d: gnt=%b to=%b, want 0001/0", n, bus4.gnt, bus4.timeout);
      end
    end
    // write in the last permitted cycle must commit
    bus4.wr_en   = 4'b0001;
    bus4.wr_slot = 8'h00;
    bus4.wr_bit  = 4'b0001;
    tick();
    bus4.wr_en  = 4'b0000;
    bus4.wr_bit = 4'b0000;
    n_checks++;
    if (bus4.slot_a !== 4'b1011) begin
      n_fail++;
      $display("FAIL hold_last_write: slot_a=%b, want 1011", bus4.slot_a);
    end
`ifdef INTF_SLOT_ARB_TIMEOUT_EN
    n_checks++;
    if (bus4.gnt !== 4'b0000 || bus4.timeout !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_pulse: gnt=%b to=%b, want 0000/1", bus4.gnt, bus4.timeout);
    end
    tick();
    n_checks++;
    if (bus4.gnt !== 4'b0010 || bus4.timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_next: gnt=%b to=%b, want 0010/0", bus4.gnt, bus4.timeout);
    end
`else
    for (int n = 0; n < 20; n++) begin
      n_checks++;
      if (bus4.gnt !== 4'b0001 || bus4.timeout !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_forever%0d: gnt=%b to=%b, want 0001/0", n, bus4.gnt, bus4.timeout);
      end
      tick();
    end
    bus4.req = 4'b0010;
    tick();
    n_checks++;
    if (bus4.gnt !== 4'b0000) begin
      n_fail++;
      $display("FAIL hold_release: gnt=%b, want 0000", bus4.gnt);
    end
    tick();
    n_checks++;
    if (bus4.gnt !== 4'b0010 || bus4.timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_next: gnt=%b to=%b, want 0010/0", bus4.gnt, bus4.timeout);
    end
`endif
    bus4.req = 4'b0000;
    tick();
  endtask

  task automatic test_reset_mid_grant();
    bus4.req = 4'b0010;
    tick();
    n_checks++;
    if (bus4.gnt !== 4'b0010) begin
      n_fail++;
      $display("FAIL mid_grant: gnt=%b, want 0010", bus4.gnt);
    end
    rst          = 1'b1;
    bus4.wr_en   = 4'b0010;
    bus4.wr_slot = 8'h00;
    bus4.wr_bit  = 4'b0010;
    tick();
    n_checks++;
    if (bus4.slot_a !== 4'b0000 || bus4.gnt !== 4'b0000 || bus4.busy !== 1'b0 || bus4.gnt_idx !== 2'd0) begin
      n_fail++;
      $display("FAIL mid_reset: slot_a=%b gnt=%b busy=%b idx=%0d, want 0000/0000/0/0",
               bus4.slot_a, bus4.gnt, bus4.busy, bus4.gnt_idx);
    end
    rst        = 1'b0;
    bus4.wr_en = 4'b0000;
    bus4.req   = 4'b1111;
    tick();
    n_checks++;
    if (bus4.gnt !== 4'b0001) begin
      n_fail++;
      $display("FAIL mid_ptr_reset: gnt=%b, want 0001", bus4.gnt);
    end
    bus4.req = 4'b0000;
    tick();
  endtask

  initial begin
    n_checks     = 0;
    n_fail       = 0;
    rst          = 1'b1;
    bus4.req     = 4'b0000;
    bus4.wr_en   = 4'b0000;
    bus4.wr_slot = 8'h00;
    bus4.wr_bit  = 4'b0000;
    bus3.req     = 4'b0000;
    bus3.wr_en   = 4'b0000;
    bus3.wr_slot = 8'h00;
    bus3.wr_bit  = 4'b0000;

    test_reset();
    test_fairness();
    test_write();
    test_bad_index();
    test_timeout();
    test_reset_mid_grant();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
